// File: rtl/mpls_cfg_cntr_regs_pkg.sv
// Shared types and constants for the MPLS config/counter register block.
// Ring FSM states, out-of-range read pattern and address-map decode.
package mpls_cfg_cntr_regs_pkg;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_WR_ACK = 1'b1
    } ring_state_e;

    typedef enum logic [1:0] {
        TGT_NONE = 2'd0,
        TGT_CFG  = 2'd1,
        TGT_CNTR = 2'd2
    } target_e;

    localparam logic [31:0] DEAD_BEEF = 32'hDEAD_BEEF;

    // Counters sit directly above the config words in local space.
    function automatic logic [31:0] cntr_base(input logic [31:0] num_cfg);
        return num_cfg;
    endfunction

    function automatic target_e decode_target(
        input logic [31:0] a,
        input logic [31:0] num_cfg,
        input logic [31:0] num_cntr
    );
        if (a < num_cfg) begin
            return TGT_CFG;
        end
        if (a < num_cfg + num_cntr) begin
            return TGT_CNTR;
        end
        return TGT_NONE;
    endfunction

endpackage

// File: rtl/mpls_cfg_cntr_regs_sat_event_counter.sv
// Saturating event counter with clear; a clear that coincides with an
// event leaves the counter at 1 so the event is not lost.
module sat_event_counter #(
    parameter int CNTR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  inc,
    input  logic                  clr,
    output logic [CNTR_WIDTH-1:0] count
);

    localparam logic [CNTR_WIDTH-1:0] MAX = '1;
    localparam logic [CNTR_WIDTH-1:0] ONE = CNTR_WIDTH'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= inc ? ONE : '0;
        end else if (inc && count != MAX) begin
            count <= count + ONE;
        end
    end

endmodule

// File: rtl/mpls_cfg_cntr_regs.sv
// UDP register-ring block: NUM_CFG config words exported on cfg_out and
// NUM_CNTR saturating event counters with clear-on-write/clear-on-read.
module mpls_cfg_cntr_regs
    import mpls_cfg_cntr_regs_pkg::*;
#(
    parameter int NUM_CFG     = 16,
    parameter int NUM_CNTR    = 8,
    parameter int CNTR_WIDTH  = 32,
    parameter int CLR_ON_READ = 0,
    parameter int ADDR_WIDTH  = 23,
    parameter int DATA_WIDTH  = 32,
    parameter int SRC_WIDTH   = 2,
    parameter int LOCAL_AW    = 8,
    parameter int BLOCK_TAG   = 0
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           reg_req_in,
    input  logic                           reg_ack_in,
    input  logic                           reg_rd_wr_L_in,
    input  logic [ADDR_WIDTH-1:0]          reg_addr_in,
    input  logic [DATA_WIDTH-1:0]          reg_data_in,
    input  logic [SRC_WIDTH-1:0]           reg_src_in,
    output logic                           reg_req_out,
    output logic                           reg_ack_out,
    output logic                           reg_rd_wr_L_out,
    output logic [ADDR_WIDTH-1:0]          reg_addr_out,
    output logic [DATA_WIDTH-1:0]          reg_data_out,
    output logic [SRC_WIDTH-1:0]           reg_src_out,
    input  logic [NUM_CNTR-1:0]            event_in,
    output logic [NUM_CFG*DATA_WIDTH-1:0]  cfg_out
);

    localparam int TAG_W = ADDR_WIDTH - LOCAL_AW;
    localparam logic [TAG_W-1:0] TAG = TAG_W'(BLOCK_TAG);
    localparam logic [31:0] N_CFG = 32'(NUM_CFG);
    localparam logic [31:0] N_CNTR = 32'(NUM_CNTR);
    localparam logic [31:0] CNTR_BASE = cntr_base(N_CFG);
    localparam logic [DATA_WIDTH-1:0] OOR_DATA = DATA_WIDTH'(DEAD_BEEF);

    ring_state_e state;
    ring_state_e state_nxt;

    logic [DATA_WIDTH-1:0] cfg_q [NUM_CFG];
    logic [CNTR_WIDTH-1:0] cnt [NUM_CNTR];
    logic [NUM_CNTR-1:0]   cnt_clr;

    logic [31:0]           a;
    logic                  hit;
    logic                  accept;
    logic                  cfg_we;
    logic                  cntr_clr_en;
    target_e               tgt;
    logic [DATA_WIDTH-1:0] rd_data;

    logic [ADDR_WIDTH-1:0] hold_addr;
    logic [DATA_WIDTH-1:0] hold_data;
    logic [SRC_WIDTH-1:0]  hold_src;
    logic                  hold_en;

    logic                  req_nxt;
    logic                  ack_nxt;
    logic                  rdwr_nxt;
    logic [ADDR_WIDTH-1:0] addr_nxt;
    logic [DATA_WIDTH-1:0] data_nxt;
    logic [SRC_WIDTH-1:0]  src_nxt;

    assign a   = 32'(reg_addr_in[LOCAL_AW-1:0]);
    assign tgt = decode_target(a, N_CFG, N_CNTR);

    // Requests already acked upstream are never claimed here.
    assign hit = reg_req_in && !reg_ack_in
              && reg_addr_in[ADDR_WIDTH-1:LOCAL_AW] == TAG;

    assign accept = (state == ST_IDLE) && hit;
    assign cfg_we = accept && !reg_rd_wr_L_in && tgt == TGT_CFG;

    assign cntr_clr_en = accept && tgt == TGT_CNTR
                      && (!reg_rd_wr_L_in || CLR_ON_READ != 0);

    always_comb begin
        rd_data = OOR_DATA;
        unique case (1'b1)
            tgt == TGT_CFG: begin
                for (int k = 0; k < NUM_CFG; k++) begin
                    if (a == 32'(k)) begin
                        rd_data = cfg_q[k];
                    end
                end
            end
            tgt == TGT_CNTR: begin
                for (int k = 0; k < NUM_CNTR; k++) begin
                    if (a == CNTR_BASE + 32'(k)) begin
                        rd_data = DATA_WIDTH'(cnt[k]);
                    end
                end
            end
            default: rd_data = OOR_DATA;
        endcase
    end

    always_comb begin
        state_nxt = state;
        req_nxt   = 1'b0;
        ack_nxt   = 1'b0;
        rdwr_nxt  = 1'b0;
        addr_nxt  = '0;
        data_nxt  = '0;
        src_nxt   = '0;
        hold_en   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (!hit) begin
                    req_nxt  = reg_req_in;
                    ack_nxt  = reg_ack_in;
                    rdwr_nxt = reg_rd_wr_L_in;
                    addr_nxt = reg_addr_in;
                    data_nxt = reg_data_in;
                    src_nxt  = reg_src_in;
                end else if (reg_rd_wr_L_in) begin
                    req_nxt  = 1'b1;
                    ack_nxt  = 1'b1;
                    rdwr_nxt = 1'b1;
                    addr_nxt = reg_addr_in;
                    data_nxt = rd_data;
                    src_nxt  = reg_src_in;
                end else begin
                    hold_en   = 1'b1;
                    state_nxt = ST_WR_ACK;
                end
            end
            ST_WR_ACK: begin
                // Ring inputs this cycle are dropped: one request in flight.
                req_nxt   = 1'b1;
                ack_nxt   = 1'b1;
                rdwr_nxt  = 1'b0;
                addr_nxt  = hold_addr;
                data_nxt  = hold_data;
                src_nxt   = hold_src;
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= ST_IDLE;
            reg_req_out     <= 1'b0;
            reg_ack_out     <= 1'b0;
            reg_rd_wr_L_out <= 1'b0;
            reg_addr_out    <= '0;
            reg_data_out    <= '0;
            reg_src_out     <= '0;
            hold_addr       <= '0;
            hold_data       <= '0;
            hold_src        <= '0;
        end else begin
            state           <= state_nxt;
            reg_req_out     <= req_nxt;
            reg_ack_out     <= ack_nxt;
            reg_rd_wr_L_out <= rdwr_nxt;
            reg_addr_out    <= addr_nxt;
            reg_data_out    <= data_nxt;
            reg_src_out     <= src_nxt;
            if (hold_en) begin
                hold_addr <= reg_addr_in;
                hold_data <= reg_data_in;
                hold_src  <= reg_src_in;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < NUM_CFG; k++) begin
                cfg_q[k] <= '0;
            end
            cfg_out <= '0;
        end else begin
            for (int k = 0; k < NUM_CFG; k++) begin
                if (cfg_we && a == 32'(k)) begin
                    cfg_q[k] <= reg_data_in;
                end
                cfg_out[k*DATA_WIDTH +: DATA_WIDTH] <= cfg_q[k];
            end
        end
    end

    for (genvar g = 0; g < NUM_CNTR; g++) begin : g_cntr
        assign cnt_clr[g] = cntr_clr_en && a == CNTR_BASE + 32'(g);

        sat_event_counter #(
            .CNTR_WIDTH(CNTR_WIDTH)
        ) u_cnt (
            .clk   (clk),
            .reset (reset),
            .inc   (event_in[g]),
            .clr   (cnt_clr[g]),
            .count (cnt[g])
        );
    end

endmodule

// File: tb/tb_mpls_cfg_cntr_regs.sv
// Scoreboard bench for mpls_cfg_cntr_regs with 4-bit counters and
// clear-on-read enabled; expected ring outputs are queued at issue time.
module tb_mpls_cfg_cntr_regs;

    localparam int NCFG = 16;
    localparam int NCNT = 8;
    localparam int CW   = 4;
    localparam int AW   = 23;
    localparam int DW   = 32;
    localparam int SW   = 2;
    localparam int LAW  = 8;
    localparam int TAG  = 5;

    localparam int K_PASS = 0;
    localparam int K_RD   = 1;
    localparam int K_WR   = 2;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            reg_req_in = 1'b0;
    logic            reg_ack_in = 1'b0;
    logic            reg_rd_wr_L_in = 1'b0;
    logic [AW-1:0]   reg_addr_in = '0;
    logic [DW-1:0]   reg_data_in = '0;
    logic [SW-1:0]   reg_src_in = '0;
    logic            reg_req_out;
    logic            reg_ack_out;
    logic            reg_rd_wr_L_out;
    logic [AW-1:0]   reg_addr_out;
    logic [DW-1:0]   reg_data_out;
    logic [SW-1:0]   reg_src_out;
    logic [NCNT-1:0] event_in = '0;
    logic [NCFG*DW-1:0] cfg_out;

    mpls_cfg_cntr_regs #(
        .NUM_CFG     (NCFG),
        .NUM_CNTR    (NCNT),
        .CNTR_WIDTH  (CW),
        .CLR_ON_READ (1),
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .SRC_WIDTH   (SW),
        .LOCAL_AW    (LAW),
        .BLOCK_TAG   (TAG)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .reg_req_in      (reg_req_in),
        .reg_ack_in      (reg_ack_in),
        .reg_rd_wr_L_in  (reg_rd_wr_L_in),
        .reg_addr_in     (reg_addr_in),
        .reg_data_in     (reg_data_in),
        .reg_src_in      (reg_src_in),
        .reg_req_out     (reg_req_out),
        .reg_ack_out     (reg_ack_out),
        .reg_rd_wr_L_out (reg_rd_wr_L_out),
        .reg_addr_out    (reg_addr_out),
        .reg_data_out    (reg_data_out),
        .reg_src_out     (reg_src_out),
        .event_in        (event_in),
        .cfg_out         (cfg_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [59:0] bits;
        int          cyc;
        string       name;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] cfg_model [NCFG];
    logic [NCFG*DW-1:0] cfg_mid;
    logic [59:0] out_bits;

    assign out_bits = {reg_req_out, reg_ack_out, reg_rd_wr_L_out,
                       reg_addr_out, reg_data_out, reg_src_out};

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (reg_req_out === 1'b1) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL spurious_out: got %0h want none", out_bits);
            end else begin
                e = sb.pop_front();
                chk({e.name, "_out"}, 64'(out_bits), 64'(e.bits));
                chk({e.name, "_cyc"}, 64'(cyc), 64'(e.cyc));
            end
        end
    end

    task automatic idle_inputs();
        reg_req_in     = 1'b0;
        reg_ack_in     = 1'b0;
        reg_rd_wr_L_in = 1'b0;
        reg_addr_in    = '0;
        reg_data_in    = '0;
        reg_src_in     = '0;
        event_in       = '0;
    endtask

    task automatic send(input string name, input int kind, input logic rd,
                        input int tag, input int a, input logic [31:0] d,
                        input logic [1:0] src, input logic ackin,
                        input logic [31:0] exp_d, input logic [7:0] ev);
        exp_t e;
        logic [AW-1:0] addr;
        @(posedge clk);
        #1;
        addr = {15'(tag), 8'(a)};
        reg_req_in     = 1'b1;
        reg_ack_in     = ackin;
        reg_rd_wr_L_in = rd;
        reg_addr_in    = addr;
        reg_data_in    = d;
        reg_src_in     = src;
        event_in       = ev;
        e.name = name;
        case (kind)
            K_PASS: begin
                e.bits = {1'b1, ackin, rd, addr, d, src};
                e.cyc  = cyc + 1;
            end
            K_RD: begin
                e.bits = {1'b1, 1'b1, 1'b1, addr, exp_d, src};
                e.cyc  = cyc + 1;
            end
            default: begin
                e.bits = {1'b1, 1'b1, 1'b0, addr, d, src};
                e.cyc  = cyc + 2;
            end
        endcase
        sb.push_back(e);
        @(posedge clk);
        #1;
        idle_inputs();
        cfg_mid = cfg_out;
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input string name, input int a, input logic [31:0] v);
        send(name, K_RD, 1'b1, TAG, a, 32'h0, 2'd1, 1'b0, v, 8'h00);
    endtask

    task automatic wr(input string name, input int a, input logic [31:0] d,
                      input logic [7:0] ev);
        send(name, K_WR, 1'b0, TAG, a, d, 2'd2, 1'b0, 32'h0, ev);
        if (a < NCFG) cfg_model[a] = d;
    endtask

    task automatic pulse(input logic [7:0] m, input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            event_in = m;
        end
        @(posedge clk);
        #1;
        event_in = '0;
    endtask

    task automatic check_cfg(input string name);
        for (int k = 0; k < NCFG; k++) begin
            chk($sformatf("%s_cfg%0d", name, k),
                64'(cfg_out[k*DW +: DW]), 64'(cfg_model[k]));
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin : stim
        for (int k = 0; k < NCFG; k++) cfg_model[k] = '0;
        idle_inputs();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ring", 64'(out_bits), 64'h0);
        check_cfg("reset");
        reset = 1'b0;

        wr("wr3", 3, 32'h0001_2345, 8'h00);
        chk("cfg3_mid", 64'(cfg_mid[3*DW +: DW]), 64'h0);
        chk("cfg3_after", 64'(cfg_out[3*DW +: DW]), 64'h0001_2345);
        rd("rd3", 3, 32'h0001_2345);

        wr("wr0", 0, 32'hCAFE_F00D, 8'h00);
        wr("wr15", 15, 32'hA5A5_0001, 8'h00);
        rd("rd0", 0, 32'hCAFE_F00D);
        rd("rd15", 15, 32'hA5A5_0001);
        check_cfg("after_wr");

        pulse(8'h04, 5);
        rd("cnt2", NCFG + 2, 32'd5);
        rd("cnt2_cor", NCFG + 2, 32'd0);

        pulse(8'h20, 20);
        rd("cnt5_sat", NCFG + 5, 32'h0000_000F);
        rd("cnt5_cor", NCFG + 5, 32'd0);

        pulse(8'h02, 3);
        wr("cnt1_clr_ev", NCFG + 1, 32'h1234_5678, 8'h02);
        rd("cnt1_one", NCFG + 1, 32'd1);
        rd("cnt1_zero", NCFG + 1, 32'd0);

        pulse(8'h08, 4);
        send("cnt3_rd_ev", K_RD, 1'b1, TAG, NCFG + 3, 32'h0, 2'd3,
             1'b0, 32'd4, 8'h08);
        rd("cnt3_one", NCFG + 3, 32'd1);
        rd("cnt3_zero", NCFG + 3, 32'd0);

        pulse(8'h81, 3);
        rd("cnt0", NCFG + 0, 32'd3);
        rd("cnt7", NCFG + 7, 32'd3);

        rd("oor_first", NCFG + NCNT, 32'hDEAD_BEEF);
        rd("oor_top", 255, 32'hDEAD_BEEF);
        wr("oor_wr", NCFG + NCNT, 32'h5555_5555, 8'h00);
        check_cfg("after_oor");

        send("tag_rd", K_PASS, 1'b1, TAG + 1, 3, 32'h0BAD_F00D, 2'd3,
             1'b0, 32'h0, 8'h00);
        send("tag_wr", K_PASS, 1'b0, TAG + 1, 3, 32'hFFFF_FFFF, 2'd1,
             1'b0, 32'h0, 8'h00);
        send("acked_wr", K_PASS, 1'b0, TAG, 3, 32'hEEEE_EEEE, 2'd2,
             1'b1, 32'h0, 8'h00);
        check_cfg("after_pass");
        rd("rd3_kept", 3, 32'h0001_2345);

        pulse(8'h40, 2);
        send("tag_cnt_rd", K_PASS, 1'b1, TAG + 1, NCFG + 6, 32'h0,
             2'd0, 1'b0, 32'h0, 8'h00);
        rd("cnt6_kept", NCFG + 6, 32'd2);

        @(posedge clk);
        #1;
        reg_req_in     = 1'b1;
        reg_rd_wr_L_in = 1'b0;
        reg_addr_in    = {15'(TAG), 8'd4};
        reg_data_in    = 32'h0000_0777;
        @(posedge clk);
        #1;
        reset = 1'b1;
        idle_inputs();
        @(posedge clk);
        #1;
        chk("rst_wrack_ring", 64'(out_bits), 64'h0);
        reset = 1'b0;
        for (int k = 0; k < NCFG; k++) cfg_model[k] = '0;
        @(posedge clk);
        #1;
        check_cfg("post_rst");
        rd("post_rst_rd3", 3, 32'h0);
        rd("post_rst_rd4", 4, 32'h0);

        repeat (4) @(posedge clk);
        #1;
        chk("sb_drain", 64'(sb.size()), 64'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
